// File: rtl/request_decoder.sv
// request_decoder: assembles a validated 2-byte host request (code, sensor address) from the UART RX byte stream
module request_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
   parameter logic [7:0]  MAX_CODE       = 8'h08,
   parameter logic [7:0]  MAX_ADDRESS    = 8'h1F
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       request_ack,
   output logic       request_valid,
   output logic [7:0] request_code,
   output logic [7:0] sensor_address,
   output logic       error_code,
   output logic       error_address,
   output logic       error_timeout,
   output logic       overrun
);
   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [1:0] {WAIT_CODE, WAIT_ADDR, PENDING} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] code_reg_q, code_reg_d;
   logic request_valid_q, request_valid_d;
   logic [7:0] request_code_q, request_code_d;
   logic [7:0] sensor_address_q, sensor_address_d;
   logic error_code_q, error_code_d;
   logic error_address_q, error_address_d;
   logic error_timeout_q, error_timeout_d;
   logic overrun_q, overrun_d;
   // next-state, inter-byte gap supervision and registered output values
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      code_reg_d       = code_reg_q;
      request_valid_d  = request_valid_q;
      request_code_d   = request_code_q;
      sensor_address_d = sensor_address_q;
      error_code_d     = 1'b0;
      error_address_d  = 1'b0;
      error_timeout_d  = 1'b0;
      overrun_d        = 1'b0;
      case (state_q)
         WAIT_CODE: begin
            if (rx_done) begin
               if (rx_data <= MAX_CODE) begin
                  code_reg_d = rx_data;
                  cnt_d      = '0;
                  state_d    = WAIT_ADDR;
               end else begin
                  error_code_d = 1'b1;
               end
            end
         end
         WAIT_ADDR: begin
            if (rx_done) begin
               if (rx_data <= MAX_ADDRESS) begin
                  sensor_address_d = rx_data;
                  request_code_d   = code_reg_q;
                  request_valid_d  = 1'b1;
                  state_d          = PENDING;
               end else begin
                  error_address_d = 1'b1;
                  state_d         = WAIT_CODE;
               end
            end else if (cnt_q == LAST) begin
               error_timeout_d = 1'b1;
               state_d         = WAIT_CODE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PENDING: begin
            overrun_d = rx_done;
            if (request_ack) begin
               request_valid_d = 1'b0;
               state_d         = WAIT_CODE;
            end
         end
         default: state_d = WAIT_CODE;
      endcase
   end
   // state and output registers; reset discards any partial or pending request
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= WAIT_CODE;
         cnt_q            <= '0;
         code_reg_q       <= '0;
         request_valid_q  <= 1'b0;
         request_code_q   <= '0;
         sensor_address_q <= '0;
         error_code_q     <= 1'b0;
         error_address_q  <= 1'b0;
         error_timeout_q  <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         code_reg_q       <= code_reg_d;
         request_valid_q  <= request_valid_d;
         request_code_q   <= request_code_d;
         sensor_address_q <= sensor_address_d;
         error_code_q     <= error_code_d;
         error_address_q  <= error_address_d;
         error_timeout_q  <= error_timeout_d;
         overrun_q        <= overrun_d;
      end
   end
   assign request_valid  = request_valid_q;
   assign request_code   = request_code_q;
   assign sensor_address = sensor_address_q;
   assign error_code     = error_code_q;
   assign error_address  = error_address_q;
   assign error_timeout  = error_timeout_q;
   assign overrun        = overrun_q;
endmodule

// File: tb/tb_request_decoder.sv
// tb_request_decoder: directed stimulus with a timestamp-based reference model checked every cycle
module tb_request_decoder;
   localparam int T = 16;
   logic clock = 1'b0;
   logic reset, rx_done, request_ack;
   logic [7:0] rx_data;
   logic request_valid, error_code, error_address, error_timeout, overrun;
   logic [7:0] request_code, sensor_address;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic m_have = 1'b0, m_pend = 1'b0;
   logic [7:0] m_code = '0;
   int m_code_cyc = 0;
   logic e_valid = 1'b0, e_ec = 1'b0, e_ea = 1'b0, e_et = 1'b0, e_ov = 1'b0;
   logic [7:0] e_code = '0, e_addr = '0;

   request_decoder #(.TIMEOUT_CYCLES(T), .MAX_CODE(8'h08), .MAX_ADDRESS(8'h1F)) dut (
      .clock(clock), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
      .request_ack(request_ack), .request_valid(request_valid), .request_code(request_code),
      .sensor_address(sensor_address), .error_code(error_code), .error_address(error_address),
      .error_timeout(error_timeout), .overrun(overrun)
   );

   always #5 clock = ~clock;

   // reference: a code byte is remembered with its arrival time; the address must follow within T cycles
   always @(posedge clock) begin
      cyc  <= cyc + 1;
      e_ec <= 1'b0;
      e_ea <= 1'b0;
      e_et <= 1'b0;
      e_ov <= 1'b0;
      if (reset) begin
         m_have <= 1'b0;
         m_pend <= 1'b0;
         e_valid <= 1'b0;
         e_code <= '0;
         e_addr <= '0;
      end else if (m_pend) begin
         e_ov <= rx_done;
         if (request_ack) begin
            m_pend  <= 1'b0;
            e_valid <= 1'b0;
         end
      end else if (m_have) begin
         if (rx_done) begin
            m_have <= 1'b0;
            if (rx_data <= 8'h1F) begin
               m_pend  <= 1'b1;
               e_valid <= 1'b1;
               e_code  <= m_code;
               e_addr  <= rx_data;
            end else e_ea <= 1'b1;
         end else if (cyc - m_code_cyc == T) begin
            m_have <= 1'b0;
            e_et   <= 1'b1;
         end
      end else if (rx_done) begin
         if (rx_data <= 8'h08) begin
            m_have     <= 1'b1;
            m_code     <= rx_data;
            m_code_cyc <= cyc;
         end else e_ec <= 1'b1;
      end
   end

   task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic compare();
      lit("request_valid", {7'd0, request_valid}, {7'd0, e_valid});
      lit("request_code", request_code, e_code);
      lit("sensor_address", sensor_address, e_addr);
      lit("error_code", {7'd0, error_code}, {7'd0, e_ec});
      lit("error_address", {7'd0, error_address}, {7'd0, e_ea});
      lit("error_timeout", {7'd0, error_timeout}, {7'd0, e_et});
      lit("overrun", {7'd0, overrun}, {7'd0, e_ov});
   endtask

   task automatic step(input logic r, input logic d, input logic [7:0] data, input logic a);
      reset = r;
      rx_done = d;
      rx_data = data;
      request_ack = a;
      @(negedge clock);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic byte_in(input logic [7:0] b);
      step(1'b0, 1'b1, b, 1'b0);
   endtask

   task automatic ack();
      step(1'b0, 1'b0, 8'h00, 1'b1);
      lit("valid_after_ack", {7'd0, request_valid}, 8'h00);
   endtask

   initial begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      lit("reset_valid", {7'd0, request_valid}, 8'h00);
      lit("reset_code", request_code, 8'h00);
      byte_in(8'h03);
      idle(9);
      byte_in(8'h05);
      lit("req1_valid", {7'd0, request_valid}, 8'h01);
      lit("req1_code", request_code, 8'h03);
      lit("req1_addr", sensor_address, 8'h05);
      idle(3);
      lit("req1_held", {7'd0, request_valid}, 8'h01);
      ack();
      idle(1);
      byte_in(8'h09);
      lit("bad_code_pulse", {7'd0, error_code}, 8'h01);
      idle(1);
      lit("bad_code_single", {7'd0, error_code}, 8'h00);
      byte_in(8'h01);
      byte_in(8'h02);
      lit("req2_code", request_code, 8'h01);
      lit("req2_addr", sensor_address, 8'h02);
      ack();
      byte_in(8'h04);
      byte_in(8'h20);
      lit("bad_addr_pulse", {7'd0, error_address}, 8'h01);
      lit("bad_addr_novalid", {7'd0, request_valid}, 8'h00);
      byte_in(8'h04);
      byte_in(8'h1F);
      lit("req3_valid", {7'd0, request_valid}, 8'h01);
      lit("req3_addr", sensor_address, 8'h1F);
      ack();
      byte_in(8'h02);
      idle(T - 1);
      lit("timeout_not_early", {7'd0, error_timeout}, 8'h00);
      idle(1);
      lit("timeout_pulse", {7'd0, error_timeout}, 8'h01);
      byte_in(8'h07);
      lit("timeout_single", {7'd0, error_timeout}, 8'h00);
      byte_in(8'h03);
      lit("req4_code", request_code, 8'h07);
      ack();
      byte_in(8'h02);
      idle(T - 1);
      byte_in(8'h06);
      lit("thresh_valid", {7'd0, request_valid}, 8'h01);
      lit("thresh_no_timeout", {7'd0, error_timeout}, 8'h00);
      lit("thresh_addr", sensor_address, 8'h06);
      idle(2);
      ack();
      byte_in(8'h00);
      byte_in(8'h01);
      byte_in(8'h05);
      lit("overrun_pulse", {7'd0, overrun}, 8'h01);
      lit("overrun_addr_kept", sensor_address, 8'h01);
      lit("overrun_valid_kept", {7'd0, request_valid}, 8'h01);
      step(1'b0, 1'b1, 8'h05, 1'b1);
      lit("overrun_ack_pulse", {7'd0, overrun}, 8'h01);
      lit("overrun_ack_valid", {7'd0, request_valid}, 8'h00);
      byte_in(8'h0A);
      byte_in(8'h0B);
      lit("b2b_code_err", {7'd0, error_code}, 8'h01);
      byte_in(8'h03);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      lit("rst_addr_code", request_code, 8'h00);
      lit("rst_addr_addr", sensor_address, 8'h00);
      byte_in(8'h05);
      byte_in(8'h06);
      lit("fresh1_code", request_code, 8'h05);
      lit("fresh1_addr", sensor_address, 8'h06);
      step(1'b1, 1'b1, 8'h01, 1'b1);
      lit("rst_pend_valid", {7'd0, request_valid}, 8'h00);
      lit("rst_pend_ovr", {7'd0, overrun}, 8'h00);
      byte_in(8'h02);
      byte_in(8'h03);
      lit("fresh2_valid", {7'd0, request_valid}, 8'h01);
      lit("fresh2_code", request_code, 8'h02);
      ack();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/request_decoder.md
Name: request_decoder

Overview:
- Receive-side counterpart of the sensor response path.
- Assembles a 2-byte host request from the UART receiver byte stream: byte 0 is the request code, byte 1 is the sensor address.
- Validates both bytes, supervises the inter-byte gap with a timeout, and holds the decoded request for the sensor controller under a valid/ack handshake.
- Sits between the UART RX block and the sensor command logic.

Parameters:
- TIMEOUT_CYCLES, 5_000_000, clock cycles allowed between code byte and address byte (100 ms at 50 MHz); must be >= 2.
- MAX_CODE, 8'h08, highest legal request code; legal range is 8'h00..MAX_CODE.
- MAX_ADDRESS, 8'h1F, highest legal sensor address.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_done  input  1  one-cycle strobe from UART RX: rx_data is valid.
- rx_data  input  8  received byte.
- request_ack  input  1  consumer has taken the pending request.
- request_valid  output  1  decoded request is held and stable.
- request_code  output  8  decoded request code.
- sensor_address  output  8  decoded sensor address.
- error_code  output  1  one-cycle pulse: illegal code byte.
- error_address  output  1  one-cycle pulse: illegal address byte.
- error_timeout  output  1  one-cycle pulse: address byte not received in time.
- overrun  output  1  one-cycle pulse: byte dropped while a request was pending.

Behaviour:
- All outputs are registered.
- Reset is synchronous; while reset is high, at every edge:
  - state <= WAIT_CODE, timeout counter <= 0;
  - request_valid, request_code, sensor_address and all pulse outputs <= 0.
- Reset overrides every other input, including mid-request and while PENDING; any pending or partial request is discarded.
- States: WAIT_CODE, WAIT_ADDR, PENDING.
- WAIT_CODE:
  - rx_done with rx_data <= MAX_CODE: latch rx_data into the code register, clear the counter, go to WAIT_ADDR.
  - rx_done with rx_data > MAX_CODE: error_code = 1 for exactly the next cycle; byte discarded; stay in WAIT_CODE.
- WAIT_ADDR:
  - The counter increments every cycle without rx_done.
  - rx_done with rx_data <= MAX_ADDRESS: latch the address, go to PENDING.
    - request_valid rises the cycle after the rx_done edge (latency 1).
    - request_code and sensor_address are updated on that same edge.
  - rx_done with rx_data > MAX_ADDRESS: error_address pulse (1 cycle); go to WAIT_CODE; outputs unchanged.
  - Counter reaches TIMEOUT_CYCLES-1 with no rx_done: error_timeout pulse (1 cycle); go to WAIT_CODE.
  - rx_done in the same cycle as the timeout threshold: the byte wins, no timeout.
- PENDING:
  - request_valid stays 1; request_code and sensor_address are stable.
  - request_ack sampled high: request_valid = 0 next cycle; go to WAIT_CODE.
  - rx_done while PENDING, including the cycle in which request_ack is high: byte dropped; overrun pulse (1 cycle); state is decided by request_ack only.
  - request_ack outside PENDING is ignored.
- request_code and sensor_address keep their last values after the handshake; they change only on acceptance of a new address byte.
- Pulse outputs never stretch: consecutive bad bytes on back-to-back rx_done strobes produce back-to-back pulses.
- At most one error pulse is active per cycle.
- No implicit data reset other than reset; the counter width is sized to TIMEOUT_CYCLES.

Test Plan:
- Reset, then rx_done 8'h03 then 8'h05 ten cycles apart.
  - request_valid=1 one cycle after the second strobe, request_code=8'h03, sensor_address=8'h05.
  - Held until request_ack; request_valid=0 the cycle after ack.
- rx_done 8'h09 (MAX_CODE=8'h08): error_code pulses for one cycle; state stays WAIT_CODE.
  - Then 8'h01, 8'h02: valid request {01,02}.
- rx_done 8'h04, then 8'h20: error_address pulses; no request_valid.
  - Then 8'h04, 8'h1F: request {04,1F} accepted.
- With TIMEOUT_CYCLES=16:
  - rx_done 8'h02, then idle: error_timeout pulses exactly once, 16 cycles after the strobe.
  - Then 8'h07 is treated as a code byte.
  - Repeat with the address strobe landing on the threshold cycle: request accepted, no timeout.
- Request {00,01} pending, then rx_done 8'h05 without ack: overrun pulses and outputs are unchanged.
  - Repeat with rx_done coinciding with request_ack: overrun pulses, request_valid=0 next cycle, state WAIT_CODE.
- Assert reset in WAIT_ADDR and again in PENDING.
  - All outputs are 0 the cycle after reset.
  - The next two bytes form a fresh request.
